// File: rtl/rtc_pkg.sv
// ---------------------------------------------------------------------------
// rtc_pkg
// Shared definitions for the RTC calendar core: field-select encodings for
// the write port, field widths, and the calendar helper functions used both
// to validate day writes and to find the end of a month when counting.
// ---------------------------------------------------------------------------
package rtc_pkg;

    typedef enum logic [2:0] {
        SEL_SEC   = 3'd0,
        SEL_MIN   = 3'd1,
        SEL_HOUR  = 3'd2,
        SEL_DAY   = 3'd3,
        SEL_MONTH = 3'd4,
        SEL_YEAR  = 3'd5
    } field_sel_e;

    localparam int SEC_W   = 6;
    localparam int MIN_W   = 6;
    localparam int HOUR_W  = 5;
    localparam int DAY_W   = 5;
    localparam int MONTH_W = 4;
    localparam int YEAR_W  = 14;
    localparam int SET_W   = 14;

    // Gregorian rule; year 0 counts as a leap year since 0 % 400 == 0.
    function automatic logic is_leap(input logic [YEAR_W-1:0] y);
        return ((y % 14'd4) == 14'd0) &&
               (((y % 14'd100) != 14'd0) || ((y % 14'd400) == 14'd0));
    endfunction

    function automatic logic [DAY_W-1:0] days_in_month(input logic [MONTH_W-1:0] m,
                                                       input logic [YEAR_W-1:0]  y);
        logic [DAY_W-1:0] len;
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: len = 5'd30;
            4'd2:                    len = is_leap(y) ? 5'd29 : 5'd28;
            default:                 len = 5'd31;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// ---------------------------------------------------------------------------
// tick_divider
// Divides the board clock down to a one-second pulse.
//   clk    : board clock (rising edge)
//   rst_n  : asynchronous active-low reset, clears the count
//   run_en : high lets the count advance; low freezes it in place
//   tick   : high during the cycle the count sits at TICK_DIV-1 while enabled
// ---------------------------------------------------------------------------
module tick_divider #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_en,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        tick    = 1'b0;
        if (run_en) begin
            if (count_q == LAST) begin
                count_d = '0;
                tick    = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/rtc_calendar_core.sv
// ---------------------------------------------------------------------------
// rtc_calendar_core
// Real-time clock with a full date calendar (leap years included) and a
// single-field write port.
//   built_in_clk, glob_rst_n : clock, asynchronous active-low reset
//   run_en                   : enables timekeeping; writes work regardless
//   mode_12h                 : 12-hour rendering on hour_disp only
//   set_valid/set_sel/set_val: one-cycle field write request
//   set_ack / set_err        : one-cycle result pulse the cycle after a write
//   tick_1hz                 : one-cycle pulse per second boundary
//   sec/min/hour/day/month/year, hour_disp, pm : current time and date
// ---------------------------------------------------------------------------
module rtc_calendar_core
    import rtc_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int YEAR_RST = 2000
) (
    input  logic               built_in_clk,
    input  logic               glob_rst_n,
    input  logic               run_en,
    input  logic               mode_12h,
    input  logic               set_valid,
    input  logic [2:0]         set_sel,
    input  logic [SET_W-1:0]   set_val,
    output logic               set_ack,
    output logic               set_err,
    output logic               tick_1hz,
    output logic [SEC_W-1:0]   sec,
    output logic [MIN_W-1:0]   min,
    output logic [HOUR_W-1:0]  hour,
    output logic [HOUR_W-1:0]  hour_disp,
    output logic               pm,
    output logic [DAY_W-1:0]   day,
    output logic [MONTH_W-1:0] month,
    output logic [YEAR_W-1:0]  year
);

    localparam logic [YEAR_W-1:0] YEAR_INIT = YEAR_W'(YEAR_RST);

    logic [SEC_W-1:0]   sec_q,   sec_d;
    logic [MIN_W-1:0]   min_q,   min_d;
    logic [HOUR_W-1:0]  hour_q,  hour_d;
    logic [DAY_W-1:0]   day_q,   day_d;
    logic [MONTH_W-1:0] month_q, month_d;
    logic [YEAR_W-1:0]  year_q,  year_d;
    logic               pending_q, pending_d;
    logic               ack_q, ack_d;
    logic               err_q, err_d;

    logic               tick;
    logic               write_ok;
    logic [DAY_W-1:0]   cur_len;
    logic [DAY_W-1:0]   new_len;

    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_divider (
        .clk    (built_in_clk),
        .rst_n  (glob_rst_n),
        .run_en (run_en),
        .tick   (tick)
    );

    // Decide whether the requested write is in range. Day limits depend on
    // the month/year as they stand before this write.
    always_comb begin
        cur_len  = days_in_month(month_q, year_q);
        write_ok = 1'b0;
        case (set_sel)
            SEL_SEC:   write_ok = (set_val < 14'd60);
            SEL_MIN:   write_ok = (set_val < 14'd60);
            SEL_HOUR:  write_ok = (set_val < 14'd24);
            SEL_DAY:   write_ok = (set_val >= 14'd1) && (set_val <= {9'd0, cur_len});
            SEL_MONTH: write_ok = (set_val >= 14'd1) && (set_val <= 14'd12);
            SEL_YEAR:  write_ok = (set_val <= 14'd9999);
            default:   write_ok = 1'b0;
        endcase
    end

    // Next-state calendar. A write always wins the cycle; a tick landing on
    // the same cycle is parked in the pending flag and applied on the next
    // write-free cycle (even with run_en low) so no second is ever dropped.
    always_comb begin
        sec_d     = sec_q;
        min_d     = min_q;
        hour_d    = hour_q;
        day_d     = day_q;
        month_d   = month_q;
        year_d    = year_q;
        pending_d = pending_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        new_len   = cur_len;

        if (set_valid) begin
            ack_d = write_ok;
            err_d = !write_ok;
            if (tick) begin
                pending_d = 1'b1;
            end
            if (write_ok) begin
                case (set_sel)
                    SEL_SEC:  sec_d  = set_val[SEC_W-1:0];
                    SEL_MIN:  min_d  = set_val[MIN_W-1:0];
                    SEL_HOUR: hour_d = set_val[HOUR_W-1:0];
                    SEL_DAY:  day_d  = set_val[DAY_W-1:0];
                    SEL_MONTH: begin
                        month_d = set_val[MONTH_W-1:0];
                        new_len = days_in_month(set_val[MONTH_W-1:0], year_q);
                        if (day_q > new_len) begin
                            day_d = new_len;
                        end
                    end
                    SEL_YEAR: begin
                        year_d  = set_val;
                        new_len = days_in_month(month_q, set_val);
                        if (day_q > new_len) begin
                            day_d = new_len;
                        end
                    end
                    default: ;
                endcase
            end
        end else if (tick || pending_q) begin
            pending_d = 1'b0;
            // Full ripple carry evaluated combinationally so the whole
            // second-to-year rollover lands on one edge.
            if (sec_q == 6'd59) begin
                sec_d = '0;
                if (min_q == 6'd59) begin
                    min_d = '0;
                    if (hour_q == 5'd23) begin
                        hour_d = '0;
                        if (day_q >= cur_len) begin
                            day_d = 5'd1;
                            if (month_q == 4'd12) begin
                                month_d = 4'd1;
                                year_d  = (year_q == 14'd9999) ? '0 : year_q + 14'd1;
                            end else begin
                                month_d = month_q + 4'd1;
                            end
                        end else begin
                            day_d = day_q + 5'd1;
                        end
                    end else begin
                        hour_d = hour_q + 5'd1;
                    end
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end
    end

    always_ff @(posedge built_in_clk or negedge glob_rst_n) begin
        if (!glob_rst_n) begin
            sec_q     <= '0;
            min_q     <= '0;
            hour_q    <= '0;
            day_q     <= 5'd1;
            month_q   <= 4'd1;
            year_q    <= YEAR_INIT;
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            sec_q     <= sec_d;
            min_q     <= min_d;
            hour_q    <= hour_d;
            day_q     <= day_d;
            month_q   <= month_d;
            year_q    <= year_d;
            pending_q <= pending_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end

    // 12-hour view: midnight hour shows as 12, afternoon hours fold to 1-11.
    always_comb begin
        hour_disp = hour_q;
        if (mode_12h) begin
            if (hour_q == 5'd0) begin
                hour_disp = 5'd12;
            end else if (hour_q > 5'd12) begin
                hour_disp = hour_q - 5'd12;
            end
        end
    end

    assign pm       = (hour_q >= 5'd12);
    assign sec      = sec_q;
    assign min      = min_q;
    assign hour     = hour_q;
    assign day      = day_q;
    assign month    = month_q;
    assign year     = year_q;
    assign set_ack  = ack_q;
    assign set_err  = err_q;
    assign tick_1hz = tick;

endmodule

// File: tb/tb_rtc_calendar_core.sv
// ---------------------------------------------------------------------------
// tb_rtc_calendar_core
// Self-checking bench for rtc_calendar_core with a one-second period of four
// clocks. A behavioural calendar model predicts results; expectations are
// queued when stimulus is driven and compared when the DUT responds.
// ---------------------------------------------------------------------------
module tb_rtc_calendar_core;

    localparam int TICK_DIV = 4;
    localparam int YEAR_RST = 2000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run_en;
    logic        mode_12h;
    logic        set_valid;
    logic [2:0]  set_sel;
    logic [13:0] set_val;
    logic        set_ack;
    logic        set_err;
    logic        tick_1hz;
    logic [5:0]  sec;
    logic [5:0]  min;
    logic [4:0]  hour;
    logic [4:0]  hour_disp;
    logic        pm;
    logic [4:0]  day;
    logic [3:0]  month;
    logic [13:0] year;

    // Free-running board clock, period 10.
    always #5 clk = ~clk;

    rtc_calendar_core #(
        .TICK_DIV (TICK_DIV),
        .YEAR_RST (YEAR_RST)
    ) dut (
        .built_in_clk (clk),
        .glob_rst_n   (rst_n),
        .run_en       (run_en),
        .mode_12h     (mode_12h),
        .set_valid    (set_valid),
        .set_sel      (set_sel),
        .set_val      (set_val),
        .set_ack      (set_ack),
        .set_err      (set_err),
        .tick_1hz     (tick_1hz),
        .sec          (sec),
        .min          (min),
        .hour         (hour),
        .hour_disp    (hour_disp),
        .pm           (pm),
        .day          (day),
        .month        (month),
        .year         (year)
    );

    int checks = 0;
    int errors = 0;

    int mSec, mMin, mHour, mDay, mMonth, mYear;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } sb_t;

    sb_t sbQ[$];

    // Single comparison point; every check goes through here.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit mLeap(input int y);
        if (y % 400 == 0) return 1'b1;
        if (y % 100 == 0) return 1'b0;
        return (y % 4 == 0);
    endfunction

    function automatic int mDim(input int m, input int y);
        int lens[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (m == 2 && mLeap(y)) return 29;
        return lens[m-1];
    endfunction

    function automatic int mDisp(input int h);
        if (h == 0) return 12;
        if (h > 12) return h - 12;
        return h;
    endfunction

    function automatic logic [63:0] modelCal();
        return {24'd0, 14'(mYear), 4'(mMonth), 5'(mDay), 5'(mHour), 6'(mMin), 6'(mSec)};
    endfunction

    function automatic logic [63:0] dutCal();
        return {24'd0, year, month, day, hour, min, sec};
    endfunction

    task automatic modelReset();
        mSec = 0; mMin = 0; mHour = 0; mDay = 1; mMonth = 1; mYear = YEAR_RST;
    endtask

    task automatic modelTick();
        mSec++;
        if (mSec == 60) begin mSec = 0; mMin++; end
        if (mMin == 60) begin mMin = 0; mHour++; end
        if (mHour == 24) begin mHour = 0; mDay++; end
        if (mDay > mDim(mMonth, mYear)) begin mDay = 1; mMonth++; end
        if (mMonth == 13) begin mMonth = 1; mYear++; end
        if (mYear == 10000) mYear = 0;
    endtask

    task automatic modelWrite(input int sel, input int v, output bit ok);
        ok = 1'b0;
        case (sel)
            0: if (v < 60) begin ok = 1'b1; mSec = v; end
            1: if (v < 60) begin ok = 1'b1; mMin = v; end
            2: if (v < 24) begin ok = 1'b1; mHour = v; end
            3: if (v >= 1 && v <= mDim(mMonth, mYear)) begin ok = 1'b1; mDay = v; end
            4: if (v >= 1 && v <= 12) begin
                   ok = 1'b1; mMonth = v;
                   if (mDay > mDim(mMonth, mYear)) mDay = mDim(mMonth, mYear);
               end
            5: if (v <= 9999) begin
                   ok = 1'b1; mYear = v;
                   if (mDay > mDim(mMonth, mYear)) mDay = mDim(mMonth, mYear);
               end
            default: ok = 1'b0;
        endcase
    endtask

    function automatic void pushExpected(input string tag, input logic [63:0] v);
        sb_t e;
        e.tag = tag;
        e.val = v;
        sbQ.push_back(e);
    endfunction

    // Pop every queued expectation and compare against the matching output.
    task automatic checkQueued();
        sb_t e;
        logic [63:0] obs;
        while (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            if (e.tag == "ack")        obs = 64'(set_ack);
            else if (e.tag == "err")   obs = 64'(set_err);
            else if (e.tag == "tick")  obs = 64'(tick_1hz);
            else if (e.tag == "hdisp") obs = 64'(hour_disp);
            else if (e.tag == "pm")    obs = 64'(pm);
            else                       obs = dutCal();
            checkOutput(e.tag, obs, e.val);
        end
    endtask

    // One field write with run_en as currently set; result checked a cycle later.
    task automatic applyStimulus(input int sel, input int v);
        bit ok;
        @(negedge clk);
        set_valid = 1'b1;
        set_sel   = 3'(sel);
        set_val   = 14'(v);
        modelWrite(sel, v, ok);
        pushExpected("ack", 64'(ok));
        pushExpected("err", 64'(!ok));
        pushExpected("cal", modelCal());
        @(posedge clk);
        #1;
        set_valid = 1'b0;
        checkQueued();
    endtask

    // Let the clock run until one second elapses, then freeze it again.
    task automatic runSecond();
        bit found;
        found = 1'b0;
        @(negedge clk);
        run_en = 1'b1;
        for (int i = 0; i < 4 * TICK_DIV; i++) begin
            @(posedge clk);
            #1;
            if (tick_1hz) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("tick_seen", 64'(found), 64'd1);
        if (found) begin
            modelTick();
            pushExpected("cal", modelCal());
            @(posedge clk);
            #1;
            checkQueued();
        end
        run_en = 1'b0;
    endtask

    task automatic setDateTime(input int y, input int mo, input int d,
                               input int h, input int mi, input int s);
        applyStimulus(5, y);
        applyStimulus(4, mo);
        applyStimulus(3, d);
        applyStimulus(2, h);
        applyStimulus(1, mi);
        applyStimulus(0, s);
    endtask

    task automatic checkHour(input int h);
        applyStimulus(2, h);
        mode_12h = 1'b1;
        #1;
        pushExpected("hdisp", 64'(mDisp(h)));
        pushExpected("pm", 64'(h >= 12));
        checkQueued();
        mode_12h = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit found;
        bit ok;

        rst_n     = 1'b0;
        run_en    = 1'b0;
        mode_12h  = 1'b0;
        set_valid = 1'b0;
        set_sel   = 3'd0;
        set_val   = 14'd0;
        modelReset();

        // Reset state while reset is held across clock edges.
        #12;
        pushExpected("rst_cal", modelCal());
        pushExpected("ack", 64'd0);
        pushExpected("err", 64'd0);
        pushExpected("tick", 64'd0);
        checkQueued();

        // Release with the clock running: tick on every fourth edge.
        @(negedge clk);
        rst_n  = 1'b1;
        run_en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (k % 4 == 0) modelTick();
            pushExpected("tick", 64'(k % 4 == 3));
            pushExpected("cal", modelCal());
            checkQueued();
        end
        run_en = 1'b0;

        // Year rollover through the whole carry chain.
        setDateTime(1999, 12, 31, 23, 59, 59);
        runSecond();

        // Century non-leap and quad-century leap February ends.
        setDateTime(2100, 2, 28, 23, 59, 59);
        runSecond();
        setDateTime(2000, 2, 28, 23, 59, 59);
        runSecond();

        // Day clamping on month change and out-of-range writes.
        applyStimulus(4, 1);
        applyStimulus(3, 31);
        applyStimulus(4, 4);
        applyStimulus(3, 31);
        applyStimulus(3, 0);
        applyStimulus(0, 60);
        applyStimulus(2, 24);
        applyStimulus(4, 13);
        applyStimulus(5, 10000);
        applyStimulus(6, 1);
        applyStimulus(7, 0);

        // Write on the tick cycle: write first, deferred second next cycle
        // even though the clock is stopped by then.
        applyStimulus(0, 10);
        @(negedge clk);
        run_en = 1'b1;
        found  = 1'b0;
        for (int i = 0; i < 4 * TICK_DIV; i++) begin
            @(posedge clk);
            #1;
            if (tick_1hz) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("tick_seen", 64'(found), 64'd1);
        set_valid = 1'b1;
        set_sel   = 3'd1;
        set_val   = 14'd5;
        modelWrite(1, 5, ok);
        pushExpected("ack", 64'(ok));
        pushExpected("err", 64'(!ok));
        pushExpected("cal", modelCal());
        @(posedge clk);
        #1;
        set_valid = 1'b0;
        run_en    = 1'b0;
        checkQueued();
        modelTick();
        pushExpected("cal", modelCal());
        @(posedge clk);
        #1;
        checkQueued();

        // 12-hour rendering.
        checkHour(0);
        checkHour(12);
        checkHour(13);
        checkHour(23);
        checkHour(7);

        // Reset in the middle of a write overrides it immediately.
        @(negedge clk);
        run_en    = 1'b1;
        set_valid = 1'b1;
        set_sel   = 3'd0;
        set_val   = 14'd30;
        #1;
        rst_n = 1'b0;
        #1;
        modelReset();
        pushExpected("midrst_cal", modelCal());
        pushExpected("ack", 64'd0);
        pushExpected("err", 64'd0);
        pushExpected("tick", 64'd0);
        checkQueued();
        set_valid = 1'b0;
        run_en    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        runSecond();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rtc_calendar_core.md
RTC_CALENDAR_CORE -- requirements
Module: rtc_calendar_core

Interface
REQ-001 Parameter TICK_DIV, default 50_000_000: built_in_clk cycles per second (50 MHz board clock); legal range 2 or more.
REQ-002 Parameter YEAR_RST, default 2000: year value loaded at reset; legal range 0-9999.
REQ-003 built_in_clk  in  1  sole clock; all state rising-edge triggered.
REQ-004 glob_rst_n  in  1  asynchronous, active-low reset.
REQ-005 run_en  in  1  high: timekeeping advances; low: divider and calendar frozen, set still accepted.
REQ-006 mode_12h  in  1  selects 12-hour rendering on hour_disp/pm; does not affect internal 24-hour count.
REQ-007 set_valid  in  1  one-cycle field-write request.
REQ-008 set_sel  in  3  field select: 0 sec, 1 min, 2 hour, 3 day, 4 month, 5 year; 6-7 illegal.
REQ-009 set_val  in  14  binary value for the selected field.
REQ-010 set_ack  out  1  one-cycle pulse, write accepted.
REQ-011 set_err  out  1  one-cycle pulse, write rejected.
REQ-012 tick_1hz  out  1  one-cycle pulse per second boundary.
REQ-013 sec, min  out  6 each  binary 0-59.
REQ-014 hour  out  5  binary 0-23.
REQ-015 hour_disp  out  5  hour in 24h form, or 1-12 when mode_12h=1; pm  out  1  high for hour 12-23.
REQ-016 day  out  5  1-31; month  out  4  1-12; year  out  14  0-9999.

Function
REQ-017 Divider counts 0..TICK_DIV-1 while run_en=1; at TICK_DIV-1 it wraps to 0 and tick_1hz is high that cycle.
REQ-018 All calendar fields update on the edge ending the tick cycle (latency 1); whole carry chain resolves in that single edge.
REQ-019 Carry chain: sec 59->0 carries min; min 59->0 carries hour; hour 23->0 carries day; day last-of-month->1 carries month; month 12->1 carries year; year 9999->0 wraps.
REQ-020 Month lengths: 31 for 1,3,5,7,8,10,12; 30 for 4,6,9,11; Feb 29 in leap years, else 28.
REQ-021 Leap year: divisible by 4 and (not divisible by 100 or divisible by 400); year 0 is leap.
REQ-022 Write accepted when set_sel 0-5 and set_val in range (sec/min 0-59, hour 0-23, day 1..length of current month/year, month 1-12, year 0-9999); field updated next edge, set_ack high that following cycle.
REQ-023 Rejected write: no state change, set_err high the following cycle; exactly one of set_ack/set_err per set_valid.
REQ-024 Month or year write making day exceed new month length clamps day to that length in the same edge.
REQ-025 Tick and accepted/rejected write in same cycle: write applied, calendar increment deferred to next cycle via one pending flag; no second is lost.
REQ-026 run_en deassert mid-count: divider holds value, resumes from it; pending increment still applied.
REQ-027 hour_disp in 12h mode: 0->12, 1-12 unchanged, 13-23 -> 1-11; combinational from hour.

Reset
REQ-028 While glob_rst_n=0: divider 0, pending 0, sec/min/hour 0, day 1, month 1, year YEAR_RST, set_ack/set_err/tick_1hz 0.
REQ-029 Reset asserted mid-operation overrides any write or tick immediately; first tick after release occurs TICK_DIV cycles after first enabled edge.

Structure
REQ-030 Shared package rtc_pkg holds field-select encodings, field widths, and days_in_month/is_leap functions.
REQ-031 One sub-module tick_divider (parameter TICK_DIV, inputs clock, reset, run_en, output tick) is instantiated once.

Verification (TICK_DIV=4)
REQ-032 Reset release, run_en=1 -> tick_1hz every 4th cycle; sec 0->1 one cycle after first tick.
REQ-033 Set 1999-12-31 23:59:59 -> next tick gives 2000-01-01 00:00:00.
REQ-034 Set 2100-02-28 23:59:59 -> next tick gives 03-01; 2000-02-28 -> 02-29.
REQ-035 Day=31, month=1, write month=4 -> set_ack, day=30; write day=31 -> set_err, day stays 30.
REQ-036 set_valid on tick cycle, sec=10, write min=5 -> min=5 then sec=11 one cycle later.
REQ-037 hour=0/12/13 with mode_12h=1 -> hour_disp 12/12/1, pm 0/1/1.
